hex_ascii_serializer: RTL

Parametrised hex-to-ASCII string serializer. Accepts a WIDTH-bit word on a valid/ready input port and emits its hexadecimal representation as ASCII characters, most-significant digit first. Output is one character per cycle on a valid/ready output port, with an optional CR/LF terminator. Selectable upper/lower case and leading-zero suppression. Sits between status/debug registers and a UART or log TX path, replacing per-nibble combinational conversion.

---
 rtl/hex_ascii_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/hex_ascii_serializer.sv
// hex_ascii_serializer: streams a WIDTH-bit word as ASCII hex digits, most significant first,
// with optional leading-zero suppression, lower-case letters and a CR/LF terminator.
module hex_ascii_serializer #(
  parameter int WIDTH   = 16,
  parameter bit TERM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_lower_i,
  input  logic             in_suppress_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_char_o,
  output logic             out_last_o
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             lower_q;
  logic [IW-1:0]    idx_q;
  logic [7:0]       char_q;
  logic             valid_q;
  logic             last_q;
  logic [IW-1:0]    top;
  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    nxt_idx;
  logic [3:0]       start_nib;
  logic [3:0]       nxt_nib;

  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_width_check
    $error("hex_ascii_serializer: WIDTH must be a multiple of 4 and at least 4");
  end

  function automatic logic [7:0] ascii(input logic [3:0] n, input logic lower);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : (lower ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  // Highest nonzero nibble; an all-zero word leaves index 0 so one '0' is still sent.
  always_comb begin
    top = '0;
    for (int i = 0; i < NIB; i++) top = in_data_i[4*i +: 4] != 4'h0 ? IW'(i) : top;
  end

  assign start_idx   = in_suppress_i ? top : IW'(NIB - 1);
  assign nxt_idx     = idx_q - IW'(1);
  assign start_nib   = 4'(in_data_i >> {start_idx, 2'b00});
  assign nxt_nib     = 4'(data_q >> {nxt_idx, 2'b00});
  assign in_ready_o  = state_q == IDLE && !rst;
  assign out_valid_o = valid_q;
  assign out_char_o  = char_q;
  assign out_last_o  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          data_q  <= in_data_i;
          lower_q <= in_lower_i;
          idx_q   <= start_idx;
          state_q <= DIGIT;
          valid_q <= 1'b1;
          char_q  <= ascii(start_nib, in_lower_i);
          last_q  <= !TERM_EN && start_idx == '0;
        end
        DIGIT: if (out_ready_i) begin
          if (idx_q != '0) begin
            idx_q  <= nxt_idx;
            char_q <= ascii(nxt_nib, lower_q);
            last_q <= !TERM_EN && idx_q == IW'(1);
          end else if (TERM_EN) begin
            state_q <= CR;
            char_q  <= 8'h0D;
            last_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            char_q  <= 8'h00;
            last_q  <= 1'b0;
          end
        end
        CR: if (out_ready_i) begin
          state_q <= LF;
          char_q  <= 8'h0A;
          last_q  <= 1'b1;
        end
        LF: if (out_ready_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          char_q  <= 8'h00;
          last_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
